// File: rtl/cache_pkg.sv
// Shared parameters and types for the L1 instruction-cache refill path.
package cache_pkg;

   localparam int unsigned INDEX_BITS     = 4;
   localparam int unsigned OFFSET_BITS    = 3;
   localparam int unsigned TAG_BITS       = 32 - INDEX_BITS - OFFSET_BITS;
   localparam int unsigned LINE_BYTES     = 8;
   localparam int unsigned CNT_WIDTH      = 16;
   localparam int unsigned WORD_BITS      = 32;
   localparam int unsigned LINE_ADDR_BITS = 32 - OFFSET_BITS;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      WAIT = 2'd2,
      FILL = 2'd3
   } refill_state_t;

   typedef logic [63:0] line_t;

endpackage : cache_pkg

// File: rtl/l1_refill_controller.sv
// L1 instruction-cache miss handler: fetches an 8-byte line as two 32-bit
// beats from backing memory and writes it into the cache in one strobe.
module l1_refill_controller
   import cache_pkg::*;
(
   input  logic                          clk,
   input  logic                          reset,
   input  logic [31:0]                   pcAddress,
   input  logic                          fetchValid,
   input  logic                          cacheHit,
   output logic                          fetchStall,
   output logic                          memReqValid,
   output logic [31:0]                   memReqAddr,
   input  logic                          memReqReady,
   input  logic                          memRespValid,
   input  logic [WORD_BITS-1:0]          memRespData,
   output logic                          writeCache,
   output logic [INDEX_BITS-1:0]         writeIndex,
   output logic [TAG_BITS-1:0]           writeTag,
   output line_t                         writeData,
   output logic                          refillBusy,
   output logic [CNT_WIDTH-1:0]          missCount
);

   refill_state_t              state_q, state_d;
   logic                       beat_q, beat_d;
   line_t                      buf_q, buf_d;
   logic [LINE_ADDR_BITS-1:0]  line_addr_q, line_addr_d;
   logic [CNT_WIDTH-1:0]       miss_cnt_q, miss_cnt_d;

   // Byte offset within the line never matters: the whole line is fetched.
   logic unused_pc_offset;
   assign unused_pc_offset = ^pcAddress[OFFSET_BITS-1:0];

   assign missCount = miss_cnt_q;

   // State, beat, line buffer, latched line address and miss counter.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         beat_q      <= 1'b0;
         buf_q       <= '0;
         line_addr_q <= '0;
         miss_cnt_q  <= '0;
      end else begin
         state_q     <= state_d;
         beat_q      <= beat_d;
         buf_q       <= buf_d;
         line_addr_q <= line_addr_d;
         miss_cnt_q  <= miss_cnt_d;
      end
   end

   // Next-state logic and Moore outputs; fetchStall also sees the live miss.
   always_comb begin
      state_d     = state_q;
      beat_d      = beat_q;
      buf_d       = buf_q;
      line_addr_d = line_addr_q;
      miss_cnt_d  = miss_cnt_q;
      memReqValid = 1'b0;
      memReqAddr  = '0;
      writeCache  = 1'b0;
      writeIndex  = '0;
      writeTag    = '0;
      writeData   = '0;
      refillBusy  = (state_q != IDLE);
      fetchStall  = (state_q != IDLE) | (fetchValid & ~cacheHit);

      case (state_q)
         IDLE: begin
            if (fetchValid && !cacheHit) begin
               line_addr_d = pcAddress[31:OFFSET_BITS];
               beat_d      = 1'b0;
               if (miss_cnt_q != {CNT_WIDTH{1'b1}}) begin
                  miss_cnt_d = miss_cnt_q + CNT_WIDTH'(1);
               end
               state_d     = REQ;
            end
         end
         REQ: begin
            memReqValid = 1'b1;
            memReqAddr  = {line_addr_q, beat_q, 2'b00};
            if (memReqReady) begin
               state_d = WAIT;
            end
         end
         WAIT: begin
            if (memRespValid) begin
               if (!beat_q) begin
                  buf_d[63:32] = memRespData;
                  beat_d       = 1'b1;
                  state_d      = REQ;
               end else begin
                  buf_d[31:0]  = memRespData;
                  state_d      = FILL;
               end
            end
         end
         FILL: begin
            writeCache = 1'b1;
            writeIndex = line_addr_q[INDEX_BITS-1:0];
            writeTag   = line_addr_q[LINE_ADDR_BITS-1:INDEX_BITS];
            writeData  = buf_q;
            state_d    = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

endmodule : l1_refill_controller

// File: tb/tb_l1_refill_controller.sv
// Self-checking bench for l1_refill_controller: the bench plays backing
// memory and predicts each refill from the missing PC and the returned words.
module tb_l1_refill_controller;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] pcAddress;
   logic        fetchValid;
   logic        cacheHit;
   logic        fetchStall;
   logic        memReqValid;
   logic [31:0] memReqAddr;
   logic        memReqReady;
   logic        memRespValid;
   logic [31:0] memRespData;
   logic        writeCache;
   logic [3:0]  writeIndex;
   logic [24:0] writeTag;
   logic [63:0] writeData;
   logic        refillBusy;
   logic [15:0] missCount;

   int          n_checks = 0;
   int          n_fail   = 0;
   logic [15:0] model_cnt = 16'h0;

   l1_refill_controller dut (
      .clk          (clk),
      .reset        (reset),
      .pcAddress    (pcAddress),
      .fetchValid   (fetchValid),
      .cacheHit     (cacheHit),
      .fetchStall   (fetchStall),
      .memReqValid  (memReqValid),
      .memReqAddr   (memReqAddr),
      .memReqReady  (memReqReady),
      .memRespValid (memRespValid),
      .memRespData  (memRespData),
      .writeCache   (writeCache),
      .writeIndex   (writeIndex),
      .writeTag     (writeTag),
      .writeData    (writeData),
      .refillBusy   (refillBusy),
      .missCount    (missCount)
   );

   always #5 clk = ~clk;

   // Count one comparison and report it if the DUT disagrees.
   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic sample();
      @(negedge clk);
   endtask

   task automatic count_miss();
      if (model_cnt != 16'hFFFF) model_cnt = model_cnt + 16'd1;
   endtask

   // One full refill starting in IDLE; returns in the IDLE cycle after FILL.
   task automatic do_refill(input logic [31:0] pc, input logic [31:0] d0, input logic [31:0] d1,
                            input int hold0, input int hold1, input int rd0, input int rd1,
                            input logic [31:0] noise_pc, input bit noise_miss);
      logic [31:0] exp_addr;
      logic [31:0] word;
      logic [63:0] exp_line;
      int          h;
      int          rd;
      exp_line     = {d0, d1};
      pcAddress    = pc;
      fetchValid   = 1'b1;
      cacheHit     = 1'b0;
      memReqReady  = 1'b0;
      memRespValid = 1'b0;
      sample();
      chk("miss_stall", 64'(fetchStall), 64'd1);
      chk("miss_idle_busy", 64'(refillBusy), 64'd0);
      count_miss();
      step();
      // Fetch keeps wandering during the refill; it must not disturb it.
      pcAddress  = noise_pc;
      fetchValid = noise_miss ? 1'b1 : 1'($urandom);
      cacheHit   = noise_miss ? 1'b0 : 1'($urandom);
      for (int b = 0; b < 2; b++) begin
         exp_addr = {pc[31:3], 3'b000} + 32'(4 * b);
         word     = (b == 0) ? d0 : d1;
         h        = (b == 0) ? hold0 : hold1;
         rd       = (b == 0) ? rd0 : rd1;
         for (int i = 0; i <= h; i++) begin
            memReqReady = (i == h);
            sample();
            chk("req_valid", 64'(memReqValid), 64'd1);
            chk("req_addr", 64'(memReqAddr), 64'(exp_addr));
            chk("req_stall", 64'(fetchStall), 64'd1);
            step();
         end
         memReqReady = 1'b0;
         for (int i = 0; i <= rd; i++) begin
            memRespValid = (i == rd);
            memRespData  = (i == rd) ? word : $urandom;
            sample();
            chk("wait_req_valid", 64'(memReqValid), 64'd0);
            chk("wait_busy", 64'(refillBusy), 64'd1);
            chk("wait_wr", 64'(writeCache), 64'd0);
            step();
         end
         memRespValid = 1'b0;
      end
      sample();
      chk("fill_strobe", 64'(writeCache), 64'd1);
      chk("fill_index", 64'(writeIndex), 64'(pc[6:3]));
      chk("fill_tag", 64'(writeTag), 64'(pc[31:7]));
      chk("fill_data", writeData, exp_line);
      chk("fill_count", 64'(missCount), 64'(model_cnt));
      chk("fill_stall", 64'(fetchStall), 64'd1);
      step();
   endtask

   // Hit cycles: no request, no stall, counter untouched.
   task automatic hit_cycles(input int n);
      for (int i = 0; i < n; i++) begin
         pcAddress  = $urandom;
         fetchValid = 1'($urandom);
         cacheHit   = 1'b1;
         sample();
         chk("hit_req", 64'(memReqValid), 64'd0);
         chk("hit_stall", 64'(fetchStall), 64'd0);
         chk("hit_busy", 64'(refillBusy), 64'd0);
         chk("hit_count", 64'(missCount), 64'(model_cnt));
         step();
      end
   endtask

   initial begin
      reset        = 1'b1;
      pcAddress    = 32'h0;
      fetchValid   = 1'b0;
      cacheHit     = 1'b0;
      memReqReady  = 1'b0;
      memRespValid = 1'b0;
      memRespData  = 32'h0;
      step();
      step();
      sample();
      chk("rst_req", 64'(memReqValid), 64'd0);
      chk("rst_wr", 64'(writeCache), 64'd0);
      chk("rst_count", 64'(missCount), 64'd0);
      chk("rst_data", writeData, 64'd0);
      step();
      reset = 1'b0;

      // Basic refill at minimum latency, stall drops at N+6.
      do_refill(32'h0000_1234, 32'hAAAA_0001, 32'hBBBB_0002, 0, 0, 0, 0, 32'h0000_1234, 1'b0);
      pcAddress  = 32'h0000_1234;
      fetchValid = 1'b1;
      cacheHit   = 1'b1;
      sample();
      chk("n6_stall", 64'(fetchStall), 64'd0);
      chk("n6_busy", 64'(refillBusy), 64'd0);
      chk("n6_count", 64'(missCount), 64'd1);
      step();

      // Reset mid-WAIT drops the refill and its late response.
      pcAddress  = 32'h0000_4448;
      fetchValid = 1'b1;
      cacheHit   = 1'b0;
      step();
      memReqReady = 1'b1;
      fetchValid  = 1'b0;
      step();
      memReqReady = 1'b0;
      sample();
      chk("pre_rst_busy", 64'(refillBusy), 64'd1);
      step();
      reset = 1'b1;
      sample();
      chk("rst_wait_busy", 64'(refillBusy), 64'd0);
      chk("rst_wait_req", 64'(memReqValid), 64'd0);
      chk("rst_wait_wr", 64'(writeCache), 64'd0);
      chk("rst_wait_count", 64'(missCount), 64'd0);
      step();
      reset        = 1'b0;
      model_cnt    = 16'h0;
      memRespValid = 1'b1;
      memRespData  = 32'hDEAD_BEEF;
      sample();
      chk("late_resp_busy", 64'(refillBusy), 64'd0);
      step();
      memRespValid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         sample();
         chk("late_resp_wr", 64'(writeCache), 64'd0);
         chk("late_resp_req", 64'(memReqValid), 64'd0);
         step();
      end

      // Backpressure: request held stable for five unready cycles.
      do_refill(32'h0000_1234, 32'h1111_2222, 32'h3333_4444, 5, 0, 0, 1, 32'h0000_9990, 1'b0);

      // Twenty cycles of hits.
      hit_cycles(20);

      // PC moves to 0x2000 mid-refill; that miss starts right after FILL.
      do_refill(32'h0000_1234, 32'h5555_6666, 32'h7777_8888, 0, 1, 2, 0, 32'h0000_2000, 1'b1);
      do_refill(32'h0000_2000, 32'h9999_AAAA, 32'hCCCC_DDDD, 0, 0, 0, 0, 32'h0000_2000, 1'b1);
      hit_cycles(2);

      // Randomized refills interleaved with hits.
      for (int k = 0; k < 12; k++) begin
         do_refill($urandom, $urandom, $urandom,
                   int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                   int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                   $urandom, 1'b0);
         hit_cycles(int'($urandom_range(0, 3)));
      end

      // Counter saturation.
      fetchValid = 1'b0;
      force dut.miss_cnt_q = 16'hFFFE;
      step();
      release dut.miss_cnt_q;
      model_cnt = 16'hFFFE;
      sample();
      chk("sat_preset", 64'(missCount), 64'hFFFE);
      step();
      do_refill(32'h0000_0100, 32'h0123_4567, 32'h89AB_CDEF, 0, 0, 0, 0, 32'h0, 1'b0);
      do_refill(32'h0000_0108, 32'hFEDC_BA98, 32'h7654_3210, 1, 0, 0, 1, 32'h0, 1'b0);
      do_refill(32'hFFFF_FFF8, 32'hA5A5_5A5A, 32'h0F0F_F0F0, 0, 2, 1, 0, 32'h0, 1'b0);
      hit_cycles(2);
      chk("sat_final", 64'(missCount), 64'hFFFF);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule : tb_l1_refill_controller
